// File: rtl/class_sum_engine.sv
// Class-sum engine: accumulates the weights of fired clauses into saturating per-class
// sums read from the weight bank, then runs a sequential argmax to pick the keyword class.
//
// state  | meaning
// IDLE   | waiting for start after reset
// ACCEPT | clause_ready high, consuming clause results
// FETCH  | reading N_CLASS weights of a fired clause, plus one drain cycle
// ARGMAX | scanning one class sum per cycle
// DONE   | result held until the next start
module class_sum_engine #(
  parameter int DEPTH_WEIGHT_BANK = 2048,
  parameter int N_CLASS           = 12,
  parameter int N_CLAUSE          = 160,
  parameter int SUM_W             = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 clause_valid,
  output logic                                 clause_ready,
  input  logic [$clog2(N_CLAUSE)-1:0]          clause_idx,
  input  logic                                 clause_fire,
  input  logic                                 clause_last,
  output logic                                 ren_weight_bank,
  output logic [$clog2(DEPTH_WEIGHT_BANK)-1:0] raddr_weight_bank,
  input  logic signed [8:0]                    weight_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(N_CLASS)-1:0]           pred_class,
  output logic signed [SUM_W-1:0]              pred_sum
);
  localparam int AW = $clog2(DEPTH_WEIGHT_BANK);
  localparam int CW = $clog2(N_CLASS);
  localparam int KW = $clog2(N_CLASS + 1);
  localparam logic signed [SUM_W:0] SUM_MAX = {2'b00, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] SUM_MIN = {2'b11, {(SUM_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_FETCH, S_ARGMAX, S_DONE} state_t;

  state_t                  state, state_nx;
  logic signed [SUM_W-1:0] sums [N_CLASS];
  logic [AW-1:0]           addr_q;
  logic [KW-1:0]           rem;
  logic                    last_q;
  logic                    rd_valid;
  logic [CW-1:0]           wr_cls;
  logic [CW-1:0]           arg_j;
  logic [CW-1:0]           best_cls;
  logic signed [SUM_W-1:0] best_sum;
  logic                    take_j;
  logic [CW-1:0]           cand_cls;
  logic signed [SUM_W-1:0] cand_sum;

  function automatic logic signed [SUM_W-1:0] sat_add(input logic signed [SUM_W-1:0] a,
                                                      input logic signed [8:0] w);
    logic signed [SUM_W:0] s;
    s = {a[SUM_W-1], a} + {{(SUM_W-8){w[8]}}, w};
    if (s > SUM_MAX) return SUM_MAX[SUM_W-1:0];
    if (s < SUM_MIN) return SUM_MIN[SUM_W-1:0];
    return s[SUM_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    clause_ready      = 1'b0;
    ren_weight_bank   = 1'b0;
    raddr_weight_bank = '0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_ACCEPT;
      S_ACCEPT: begin
        clause_ready = 1'b1;
        if (clause_valid) begin
          if (clause_fire)      state_nx = S_FETCH;
          else if (clause_last) state_nx = S_ARGMAX;
        end
      end
      S_FETCH: begin
        if (rem != KW'(0)) begin
          ren_weight_bank   = 1'b1;
          raddr_weight_bank = addr_q;
        end else begin
          state_nx = last_q ? S_ARGMAX : S_ACCEPT;
        end
      end
      S_ARGMAX: if (arg_j == CW'(N_CLASS - 1)) state_nx = S_DONE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // The first examined class always seeds the running best; later ones need strictly greater.
  always_comb begin
    take_j   = (arg_j == '0) || (sums[arg_j] > best_sum);
    cand_cls = take_j ? arg_j : best_cls;
    cand_sum = take_j ? sums[arg_j] : best_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CLASS; c++) sums[c] <= '0;
      addr_q     <= '0;
      rem        <= '0;
      last_q     <= 1'b0;
      rd_valid   <= 1'b0;
      wr_cls     <= '0;
      arg_j      <= '0;
      best_cls   <= '0;
      best_sum   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pred_class <= '0;
      pred_sum   <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= ren_weight_bank;
      arg_j    <= '0;
      if (rd_valid) begin
        sums[wr_cls] <= sat_add(sums[wr_cls], weight_data);
        wr_cls       <= wr_cls + CW'(1);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int c = 0; c < N_CLASS; c++) sums[c] <= '0;
            busy <= 1'b1;
          end
        end
        S_ACCEPT: begin
          if (clause_valid && clause_fire) begin
            addr_q <= AW'(clause_idx) * AW'(N_CLASS);
            rem    <= KW'(N_CLASS);
            last_q <= clause_last;
            wr_cls <= '0;
          end
        end
        S_FETCH: begin
          if (rem != KW'(0)) begin
            rem    <= rem - KW'(1);
            addr_q <= addr_q + AW'(1);
          end
        end
        S_ARGMAX: begin
          best_cls <= cand_cls;
          best_sum <= cand_sum;
          arg_j    <= arg_j + CW'(1);
          if (arg_j == CW'(N_CLASS - 1)) begin
            pred_class <= cand_cls;
            pred_sum   <= cand_sum;
            done       <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
